mem_load_arbiter: RTL and testbench
===================================

MEM_LOAD_ARBITER -- requirements
Module: mem_load_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit words loaded per UART load (power of two, at most 16).
REQ-002 Parameter ADDR_W, default 4, memory address width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 load_start  input  1  single-cycle request to begin a UART image load.
REQ-006 load_abort  input  1  terminate an active load immediately.
REQ-007 rx_valid  input  1  single-cycle strobe: rx_byte holds a received UART byte.
REQ-008 rx_byte  input  8  received UART byte.
REQ-009 cpu_req  input  1  CPU data-memory access request.
REQ-010 cpu_we  input  1  CPU write enable, qualified by cpu_req.
REQ-011 cpu_addr  input  ADDR_W  CPU memory address.
REQ-012 cpu_wdata  input  16  CPU write data.
REQ-013 cpu_stall  output  1  CPU access blocked this cycle; CPU holds its request.
REQ-014 mem_we  output  1  write enable to data memory.
REQ-015 mem_addr  output  ADDR_W  address to data memory.
REQ-016 mem_wdata  output  16  write data to data memory.
REQ-017 load_busy  output  1  loader owns the memory port.
REQ-018 load_done  output  1  one-cycle pulse when a load completes or aborts.
REQ-019 load_count  output  ADDR_W+1  words written by current/last load.
REQ-020 load_err  output  1  checksum mismatch flag (see Configuration).

Function
REQ-021 FSM states: IDLE, WAIT_LO, WAIT_HI, WRITE, DONE (plus CHK_LO, CHK_HI when configured).
REQ-022 IDLE: load_start -> WAIT_LO, clear load pointer, load_count and load_err; rx_valid ignored, including when coincident with load_start.
REQ-023 WAIT_LO: rx_valid captures rx_byte as low byte -> WAIT_HI.
REQ-024 WAIT_HI: rx_valid captures rx_byte as high byte -> WRITE.
REQ-025 WRITE lasts exactly one cycle: mem_we=1, mem_addr=load pointer, mem_wdata={high,low}; pointer and load_count increment at the cycle end.
REQ-026 WRITE exit: load_count reaching DEPTH -> DONE (or CHK_LO); else rx_valid in the WRITE cycle captured as next low byte -> WAIT_HI; otherwise -> WAIT_LO.
REQ-027 DONE lasts one cycle, load_done=1, then -> IDLE.
REQ-028 load_abort in any state other than IDLE/DONE -> DONE next cycle, no further write; abort has priority over rx_valid and the WRITE cycle's write is suppressed if coincident.
REQ-029 load_start while not IDLE is ignored.
REQ-030 load_busy=1 in every state except IDLE.
REQ-031 In IDLE: mem_we=cpu_req&cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, combinationally; cpu_stall=0.
REQ-032 In any other state: mem_addr/mem_wdata driven by loader, cpu_stall=cpu_req, CPU write never reaches memory.
REQ-033 Pointer wraps modulo 2^ADDR_W; load_count saturates at DEPTH and holds until next load_start.

Reset
REQ-034 On reset low: state IDLE, pointer 0, byte registers 0, load_count 0, load_err 0, load_done 0, load_busy 0.
REQ-035 Reset mid-load abandons the load with no write and no load_done pulse.

Configuration
REQ-036 Macro LOAD_CHECKSUM_EN defined: after DEPTH words, CHK_LO/CHK_HI receive a 16-bit checksum (low byte first), compared with running XOR of all written words; load_err=1 on mismatch, set entering DONE, held until next load_start.
REQ-037 LOAD_CHECKSUM_EN undefined: CHK states and XOR register absent, WRITE of last word -> DONE, load_err constant 0.

Verification
REQ-038 Idle CPU: cpu_req=1, cpu_we=1, addr=3, wdata=16'hBEEF -> same cycle mem_we=1, mem_addr=3, mem_wdata=16'hBEEF, cpu_stall=0.
REQ-039 Full load: load_start, bytes 34,12,78,56,... for 16 words -> mem[0]=16'h1234, mem[1]=16'h5678, ..., load_count=16, one load_done pulse, then IDLE.
REQ-040 CPU during load: cpu_req=1, cpu_we=1 while WAIT_HI -> cpu_stall=1, no CPU write; after DONE CPU write proceeds in IDLE.
REQ-041 Abort after 5 words and one low byte -> DONE next cycle, load_count=5, no 6th write, load_done pulse.
REQ-042 Back-to-back: rx_valid in WRITE cycle -> byte taken as next low byte, no byte lost.
REQ-043 With LOAD_CHECKSUM_EN: correct XOR word -> load_err=0; checksum XOR 16'h0001 -> load_err=1, cleared by next load_start.

Source files
------------

// File: rtl/mem_load_arbiter.sv
// mem_load_arbiter: shares one data-memory write port between the CPU and a
// UART image loader. While idle the CPU drives the memory directly; once a
// load starts, the loader assembles 16-bit words from pairs of received
// bytes (low byte first) and writes them to consecutive addresses while the
// CPU is stalled.
//
// Optional feature (compile-time macro LOAD_CHECKSUM_EN): after DEPTH words
// a 16-bit checksum (low byte first) is received and compared against the
// running XOR of all written words; load_err flags a mismatch.
module mem_load_arbiter #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_LO = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
`ifdef LOAD_CHECKSUM_EN
    ,
    S_CHK_LO  = 3'd5,
    S_CHK_HI  = 3'd6
`endif
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;

  // Datapath strobes decoded by the FSM
  logic clr_c;
  logic cap_lo_c;
  logic cap_hi_c;
  logic wr_c;
  logic last_word_c;

`ifdef LOAD_CHECKSUM_EN
  logic [15:0] xor_q;
  logic        err_q;
  logic        chk_cmp_c;
`endif

  assign last_word_c = (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, memory-port mux and datapath strobes
  always_comb begin
    state_d   = state_q;
    clr_c     = 1'b0;
    cap_lo_c  = 1'b0;
    cap_hi_c  = 1'b0;
    wr_c      = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    chk_cmp_c = 1'b0;
`endif
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = {hi_q, lo_q};
    cpu_stall = cpu_req;

    case (state_q)
      S_IDLE: begin
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (load_start) begin
          clr_c   = 1'b1;
          state_d = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (load_abort) begin
          state_d = S_DONE;
        end else if (rx_valid) begin
          cap_lo_c = 1'b1;
          state_d  = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        if (load_abort) begin
          state_d = S_DONE;
        end else if (rx_valid) begin
          cap_hi_c = 1'b1;
          state_d  = S_WRITE;
        end
      end

      S_WRITE: begin
        if (load_abort) begin
          state_d = S_DONE;
        end else begin
          wr_c   = 1'b1;
          mem_we = 1'b1;
          if (last_word_c) begin
`ifdef LOAD_CHECKSUM_EN
            state_d = S_CHK_LO;
`else
            state_d = S_DONE;
`endif
          end else if (rx_valid) begin
            // Byte arriving during the write is the next word's low byte
            cap_lo_c = 1'b1;
            state_d  = S_WAIT_HI;
          end else begin
            state_d = S_WAIT_LO;
          end
        end
      end

`ifdef LOAD_CHECKSUM_EN
      S_CHK_LO: begin
        if (load_abort) begin
          state_d = S_DONE;
        end else if (rx_valid) begin
          cap_lo_c = 1'b1;
          state_d  = S_CHK_HI;
        end
      end

      S_CHK_HI: begin
        if (load_abort) begin
          state_d = S_DONE;
        end else if (rx_valid) begin
          chk_cmp_c = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load pointer, word count and received-byte registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      if (clr_c) begin
        ptr_q <= '0;
        cnt_q <= '0;
      end else if (wr_c) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        if (cnt_q != FULL_CNT) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (cap_lo_c) begin
        lo_q <= rx_byte;
      end
      if (cap_hi_c) begin
        hi_q <= rx_byte;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  // Running XOR of written words and checksum-mismatch flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (clr_c) begin
        xor_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (wr_c) begin
          xor_q <= xor_q ^ {hi_q, lo_q};
        end
        if (chk_cmp_c) begin
          err_q <= ({rx_byte, lo_q} != xor_q);
        end
      end
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign load_busy  = (state_q != S_IDLE);
  assign load_done  = (state_q == S_DONE);
  assign load_count = cnt_q;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Self-checking bench for mem_load_arbiter: table-driven idle CPU vectors,
// directed load sequences (full, back-to-back, abort, reset mid-load) and
// randomized loads checked against a transaction-level reference model.
module tb_mem_load_arbiter;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int          NB     = 2 * DEPTH;
`ifdef LOAD_CHECKSUM_EN
  localparam bit CKS_ON = 1'b1;
`else
  localparam bit CKS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic              load_abort;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  mem_load_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_abort (load_abort),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Attached data memory and done-pulse counter
  logic [15:0] tb_mem [DEPTH];
  int          wr_events   = 0;
  int          done_pulses = 0;

  always @(posedge clk) begin
    if (reset && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_events        <= wr_events + 1;
    end
    if (reset && load_done) begin
      done_pulses <= done_pulses + 1;
    end
  end

  // Reference memory image and per-load stimulus
  logic [15:0] exp_mem [DEPTH];
  logic [7:0]  bb [NB];
  int          gp [NB];

  typedef struct {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wd;
    logic              exp_we;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cpu(input bit noise);
    cpu_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cpu_we    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    cpu_addr  = ADDR_W'($urandom);
    cpu_wdata = 16'($urandom);
  endtask

  // One cycle with the loader active; inputs applied at negedge, outputs checked #1 later
  task automatic busy_cycle(input bit rxv, input logic [7:0] b, input bit abort,
                            input bit exp_we, input bit noise);
    rx_valid   = rxv;
    rx_byte    = b;
    load_abort = abort;
    drive_cpu(noise);
    #1;
    check("busy", load_busy, 1'b1);
    check("stall", cpu_stall, cpu_req);
    check("load_we", mem_we, exp_we);
    check("no_done", load_done, 1'b0);
    @(negedge clk);
    rx_valid   = 1'b0;
    load_abort = 1'b0;
  endtask

  // Idle-state cycle: CPU passthrough, model memory follows CPU writes
  task automatic idle_cycle(input bit noise);
    drive_cpu(noise);
    #1;
    check("idle_busy", load_busy, 1'b0);
    check("idle_stall", cpu_stall, 1'b0);
    check("idle_we", mem_we, cpu_req & cpu_we);
    if (cpu_req && cpu_we) begin
      check("idle_addr", mem_addr, cpu_addr);
      check("idle_wdata", mem_wdata, cpu_wdata);
      exp_mem[cpu_addr] = cpu_wdata;
    end
    @(negedge clk);
  endtask

  task automatic compare_mem(input string tag);
    for (int j = 0; j < DEPTH; j++) begin
      check(tag, tb_mem[j], exp_mem[j]);
    end
  endtask

  // One whole load: bytes bb[] with idle gaps gp[], optional abort after
  // abort_after bytes (abort_gap cycles after the last byte, or after the
  // start cycle when no byte was sent).
  task automatic run_trial(input int abort_after, input int abort_gap, input bit noise,
                           input bit start_rx, input bit cks_flip);
    int   nsend;
    int   words;
    int   done0;
    bit   hi_prev;
    logic exp_err;

    nsend = (abort_after < NB) ? abort_after : NB;
    words = nsend / 2;
    // A word whose write cycle coincides with the abort is never written
    if (abort_after < NB && nsend > 0 && (nsend % 2) == 0 && abort_gap == 1) begin
      words = words - 1;
    end
    exp_err = (abort_after >= NB) && cks_flip && CKS_ON;
    done0   = done_pulses;

    // Start cycle: still idle, coincident rx byte must be ignored
    load_start = 1'b1;
    rx_valid   = start_rx;
    rx_byte    = 8'hA5;
    load_abort = 1'b0;
    idle_cycle(noise);
    load_start = 1'b0;
    rx_valid   = 1'b0;

    hi_prev = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      for (int g = 0; g < gp[i]; g++) begin
        busy_cycle(1'b0, 8'h00, 1'b0, hi_prev, noise);
        hi_prev = 1'b0;
      end
      busy_cycle(1'b1, bb[i], 1'b0, hi_prev, noise);
      hi_prev = (i % 2) == 1;
    end

    if (abort_after < NB) begin
      for (int g = 1; g < abort_gap; g++) begin
        busy_cycle(1'b0, 8'h00, 1'b0, hi_prev, noise);
        hi_prev = 1'b0;
      end
      busy_cycle(1'b0, 8'h00, 1'b1, 1'b0, noise);
    end else begin
      busy_cycle(1'b0, 8'h00, 1'b0, 1'b1, noise);
`ifdef LOAD_CHECKSUM_EN
      begin
        logic [15:0] xw;
        xw = '0;
        for (int j = 0; j < DEPTH; j++) xw = xw ^ {bb[2*j+1], bb[2*j]};
        if (cks_flip) xw = xw ^ 16'h0001;
        busy_cycle(1'b1, xw[7:0], 1'b0, 1'b0, noise);
        busy_cycle(1'b1, xw[15:8], 1'b0, 1'b0, noise);
      end
`endif
    end

    // Done cycle
    drive_cpu(noise);
    #1;
    check("done_pulse", load_done, 1'b1);
    check("done_busy", load_busy, 1'b1);
    check("done_stall", cpu_stall, cpu_req);
    check("done_we", mem_we, 1'b0);
    @(negedge clk);

    for (int j = 0; j < words; j++) begin
      exp_mem[j] = {bb[2*j+1], bb[2*j]};
    end
    idle_cycle(noise);
    check("load_count", load_count, words);
    check("load_err", load_err, exp_err);
    check("done_once", done_pulses - done0, 1);
    compare_mem("mem");
  endtask

  vec_t vt [6];

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = '0;
    cpu_wdata  = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", load_busy, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_count", load_count, 0);
    check("rst_err", load_err, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Idle CPU passthrough table
    vt[0] = '{req: 1'b1, we: 1'b1, addr: 4'd3,  wd: 16'hBEEF, exp_we: 1'b1};
    vt[1] = '{req: 1'b1, we: 1'b0, addr: 4'd5,  wd: 16'h1111, exp_we: 1'b0};
    vt[2] = '{req: 1'b0, we: 1'b1, addr: 4'd6,  wd: 16'h2222, exp_we: 1'b0};
    vt[3] = '{req: 1'b1, we: 1'b1, addr: 4'd15, wd: 16'hFFFF, exp_we: 1'b1};
    vt[4] = '{req: 1'b1, we: 1'b1, addr: 4'd0,  wd: 16'h0000, exp_we: 1'b1};
    vt[5] = '{req: 1'b0, we: 1'b0, addr: 4'd9,  wd: 16'hA5A5, exp_we: 1'b0};
    for (int k = 0; k < 6; k++) begin
      cpu_req   = vt[k].req;
      cpu_we    = vt[k].we;
      cpu_addr  = vt[k].addr;
      cpu_wdata = vt[k].wd;
      #1;
      check("vec_we", mem_we, vt[k].exp_we);
      check("vec_addr", mem_addr, vt[k].addr);
      check("vec_wdata", mem_wdata, vt[k].wd);
      check("vec_stall", cpu_stall, 1'b0);
      check("vec_busy", load_busy, 1'b0);
      @(negedge clk);
    end

    // Fill memory through the CPU path so every entry is known
    for (int a = 0; a < DEPTH; a++) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = ADDR_W'(a);
      cpu_wdata = 16'hC000 + 16'(a);
      exp_mem[a] = cpu_wdata;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
    compare_mem("fill");

    // Full load 1234,5678,... with one-cycle gaps, rx coincident with start
    for (int j = 0; j < DEPTH; j++) begin
      logic [15:0] w;
      w = 16'h1234 + 16'(j) * 16'h4444;
      bb[2*j]   = w[7:0];
      bb[2*j+1] = w[15:8];
    end
    for (int i = 0; i < NB; i++) gp[i] = 1;
    run_trial(NB, 0, 1'b0, 1'b1, 1'b0);

    // Count holds at DEPTH; abort/start-less idle cycles leave it alone
    load_abort = 1'b1;
    idle_cycle(1'b1);
    load_abort = 1'b0;
    idle_cycle(1'b1);
    check("count_hold", load_count, DEPTH);

    // Back-to-back bytes with CPU traffic during the load
    for (int i = 0; i < NB; i++) begin
      bb[i] = 8'($urandom);
      gp[i] = 0;
    end
    run_trial(NB, 0, 1'b1, 1'b0, 1'b1);

    // Abort after 5 words and one low byte
    for (int i = 0; i < NB; i++) gp[i] = i % 3;
    run_trial(11, 1, 1'b1, 1'b0, 1'b0);

    // Abort coincident with the write cycle of word 5
    run_trial(10, 1, 1'b0, 1'b0, 1'b0);

    // Abort before any byte
    run_trial(0, 2, 1'b1, 1'b0, 1'b0);

    // Reset mid-load: word 0 written, no done pulse afterwards
    begin
      int d0;
      d0 = done_pulses;
      load_start = 1'b1;
      idle_cycle(1'b0);
      load_start = 1'b0;
      busy_cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
      busy_cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
      busy_cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
      exp_mem[0] = 16'h2211;
      reset = 1'b0;
      #1;
      check("rstmid_busy", load_busy, 1'b0);
      check("rstmid_count", load_count, 0);
      check("rstmid_done", load_done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      idle_cycle(1'b0);
      check("rstmid_nodone", done_pulses - d0, 0);
      compare_mem("rstmid_mem");
    end

    // Randomized loads
    for (int t = 0; t < 30; t++) begin
      int ab;
      int ag;
      for (int i = 0; i < NB; i++) begin
        bb[i] = 8'($urandom);
        gp[i] = int'($urandom_range(0, 2));
      end
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB - 1)) : NB;
      ag = int'($urandom_range(1, 3));
      run_trial(ab, ag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) idle_cycle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
